// File: rtl/alu_add_sequencer.sv
// Sequencer for the ALU's shared 8-bit adder: ADD/SUB/CMP in one pass, MUL as an 8-step shift-and-add.
// Optional ADC/SBC carry chaining is enabled by defining ALU_SEQ_CARRY_CHAIN_EN.
module alu_add_sequencer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  input  logic                req_chain,
`endif
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [2*DATA_W-1:0] resp_result,
  output logic [3:0]          resp_flags,
  output logic [DATA_W-1:0]   add_x,
  output logic [DATA_W-1:0]   add_y,
  output logic                add_cin,
  input  logic [DATA_W-1:0]   add_sum,
  input  logic                add_cout,
  input  logic                add_ovf
);
  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  hi_q;
  logic [DATA_W-1:0]  lo_q;
  logic [CNT_W-1:0]   cnt_q;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic               cflag;
`endif

  // Adder operands for the first working cycle, registered at the accept edge
  logic [DATA_W-1:0]  start_y_c;
  logic               start_cin_c;

  always_comb begin
    start_y_c   = req_b;
    start_cin_c = 1'b0;
    unique case (req_op)
      OP_SUB, OP_CMP: begin
        start_y_c   = ~req_b;
        start_cin_c = 1'b1;
      end
      OP_MUL:  start_y_c = req_b[0] ? req_a : '0;
      default: ;
    endcase
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    if (req_chain && (req_op == OP_ADD || req_op == OP_SUB))
      start_cin_c = cflag;
`endif
  end

  // One shift-and-add step: {hi,lo} <= {cout,sum,lo} >> 1
  logic [DATA_W-1:0]  hi_nxt_c;
  logic [DATA_W-1:0]  lo_nxt_c;

  assign hi_nxt_c = {add_cout, add_sum[DATA_W-1:1]};
  assign lo_nxt_c = {add_sum[0], lo_q[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_flags  <= '0;
      add_x       <= '0;
      add_y       <= '0;
      add_cin     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      cflag       <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            a_q       <= req_a;
            hi_q      <= '0;
            lo_q      <= req_b;
            cnt_q     <= '0;
            req_ready <= 1'b0;
            add_x     <= (req_op == OP_MUL) ? '0 : req_a;
            add_y     <= start_y_c;
            add_cin   <= start_cin_c;
            state     <= (req_op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_result <= (op_q == OP_CMP) ? '0 : RES_W'(add_sum);
          resp_flags  <= {add_cout, add_ovf, add_sum == '0, add_sum[DATA_W-1]};
`ifdef ALU_SEQ_CARRY_CHAIN_EN
          if (op_q != OP_CMP)
            cflag <= add_cout;
`endif
          add_x      <= '0;
          add_y      <= '0;
          add_cin    <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_DONE;
        end
        ST_MUL: begin
          hi_q  <= hi_nxt_c;
          lo_q  <= lo_nxt_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            resp_result <= {hi_nxt_c, lo_nxt_c};
            resp_flags  <= {hi_nxt_c != '0, 1'b0, {hi_nxt_c, lo_nxt_c} == '0, 1'b0};
            add_x       <= '0;
            add_y       <= '0;
            resp_valid  <= 1'b1;
            state       <= ST_DONE;
          end else begin
            add_x <= hi_nxt_c;
            add_y <= lo_nxt_c[0] ? a_q : '0;
          end
          add_cin <= 1'b0;
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Self-checking bench for alu_add_sequencer: behavioural adder plus an arithmetic reference model.
// Build with ALU_SEQ_CARRY_CHAIN_EN defined to also exercise ADC/SBC chaining.
module tb_alu_add_sequencer;
  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic        req_chain;
`endif
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_result;
  logic [3:0]  resp_flags;
  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic        add_ovf;

  int vectors     = 0;
  int miscompares = 0;
  bit m_cflag     = 1'b0;

  alu_add_sequencer #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    .req_chain  (req_chain),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_flags (resp_flags),
    .add_x      (add_x),
    .add_y      (add_y),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .add_ovf    (add_ovf)
  );

  // The shared ripple adder the controller drives
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {8'h00, add_cin};
  assign add_ovf = (add_x[7] == add_y[7]) && (add_sum[7] != add_x[7]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result/flags from plain integer arithmetic; tracks the chained carry
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ch, output logic [15:0] r, output logic [3:0] f);
    int ua, ub, sa, sb, res, sres, bw;
    logic [7:0] s8;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = 0;
    sres = 0;
    case (op)
      2'b00: begin
        bw   = ch ? int'(m_cflag) : 0;
        res  = ua + ub + bw;
        sres = sa + sb + bw;
      end
      2'b01, 2'b11: begin
        bw   = (op == 2'b01 && ch) ? 1 - int'(m_cflag) : 0;
        res  = ua - ub - bw;
        sres = sa - sb - bw;
      end
      default: res = ua * ub;
    endcase
    if (op == 2'b10) begin
      r = 16'(res);
      f = {res > 255, 1'b0, res == 0, 1'b0};
    end else begin
      s8 = 8'(res);
      c  = (op == 2'b00) ? (res > 255) : (res >= 0);
      v  = (sres > 127) || (sres < -128);
      f  = {c, v, s8 == 8'h00, s8[7]};
      r  = (op == 2'b11) ? 16'h0000 : {8'h00, s8};
      if (op != 2'b11) m_cflag = c;
    end
  endtask

  // One full transaction from a negedge in IDLE; hold = cycles of resp backpressure
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic chain, input int hold,
                        output logic [15:0] r_obs, output logic [3:0] f_obs);
    logic [15:0] er;
    logic [3:0]  ef;
    logic [7:0]  ex, ey;
    logic        ecin, ch;
    int          n;
    bit          rr_bad;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    ch = chain;
`else
    ch = 1'b0 & chain;
`endif
    ex   = (op == 2'b10) ? 8'h00 : a;
    ey   = (op == 2'b00) ? b : (op == 2'b10) ? (b[0] ? a : 8'h00) : ~b;
    ecin = (op == 2'b00) ? (ch & m_cflag) :
           (op == 2'b01) ? (ch ? m_cflag : 1'b1) :
           (op == 2'b11);
    model(op, a, b, ch, er, ef);
    chk("ready_in_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    req_chain = ch;
`endif
    @(negedge clk);
    req_valid = 1'b0;
    chk("adder_drive_t1", 64'({add_x, add_y, add_cin}), 64'({ex, ey, ecin}));
    n = 1;
    rr_bad = (req_ready !== 1'b0);
    while (resp_valid !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
      if (req_ready !== 1'b0) rr_bad = 1'b1;
    end
    chk("latency", 64'(n), (op == 2'b10) ? 64'(9) : 64'(2));
    chk("ready_low_busy", 64'(rr_bad), 64'(0));
    chk("result", 64'(resp_result), 64'(er));
    chk("flags", 64'(resp_flags), 64'(ef));
    chk("adder_idle_done", 64'({add_x, add_y, add_cin}), 64'(0));
    r_obs = resp_result;
    f_obs = resp_flags;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_op    = 2'($urandom);
      req_a     = 8'($urandom);
      req_b     = 8'($urandom);
      @(negedge clk);
      chk("backpressure_hold", 64'({resp_valid, req_ready, resp_result, resp_flags}),
          64'({1'b1, 1'b0, er, ef}));
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("release_to_idle", 64'({resp_valid, req_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    bit          seen;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = 8'h00;
    req_b      = 8'h00;
    resp_ready = 1'b0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    req_chain  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_state", 64'({req_ready, resp_valid, resp_result, resp_flags, add_x, add_y, add_cin}),
        64'({1'b1, 1'b0, 16'h0000, 4'h0, 8'h00, 8'h00, 1'b0}));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases
    run_op(2'b00, 8'h7F, 8'h01, 1'b0, 0, r, f);
    chk("add_7f_01", 64'({r, f}), 64'({16'h0080, 4'b0101}));
    run_op(2'b01, 8'h05, 8'h07, 1'b0, 0, r, f);
    chk("sub_05_07", 64'({r, f}), 64'({16'h00FE, 4'b0001}));
    run_op(2'b11, 8'h3C, 8'h3C, 1'b0, 0, r, f);
    chk("cmp_eq", 64'({r, f}), 64'({16'h0000, 4'b1010}));
    run_op(2'b10, 8'hFF, 8'hFF, 1'b0, 0, r, f);
    chk("mul_ff_ff", 64'({r, f[3], f[1]}), 64'({16'hFE01, 1'b1, 1'b0}));
    run_op(2'b01, 8'h80, 8'h01, 1'b0, 0, r, f);
    run_op(2'b00, 8'hFF, 8'h01, 1'b0, 0, r, f);
    run_op(2'b10, 8'h00, 8'h9A, 1'b0, 0, r, f);

    // Backpressure with ignored requests, then confirm nothing was latched
    run_op(2'b00, 8'h10, 8'h20, 1'b0, 5, r, f);
    chk("bp_result", 64'(r), 64'(16'h0030));
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
    end
    chk("bp_req_ignored", 64'(seen), 64'(0));

    // Asynchronous reset during MUL iteration 4
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_a     = 8'hAB;
    req_b     = 8'hCD;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({req_ready, resp_valid, resp_result, resp_flags, add_x, add_y, add_cin}),
        64'({1'b1, 1'b0, 16'h0000, 4'h0, 8'h00, 8'h00, 1'b0}));
    m_cflag = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    chk("no_resp_after_reset", 64'(seen), 64'(0));
    run_op(2'b10, 8'h03, 8'h04, 1'b0, 0, r, f);
    chk("mul_03_04", 64'(r), 64'(16'h000C));

`ifdef ALU_SEQ_CARRY_CHAIN_EN
    run_op(2'b00, 8'hFF, 8'h01, 1'b0, 0, r, f);
    chk("chain_carry_set", 64'(f[3]), 64'(1));
    run_op(2'b00, 8'h00, 8'h00, 1'b1, 0, r, f);
    chk("adc_result", 64'({r, f[3]}), 64'({16'h0001, 1'b0}));
`endif

    // Randomised traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), $urandom_range(0, 2), r, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
